// File: rtl/iomem_timer.sv
// Purpose     : 32-bit down-counting timer on the PicoSoC iomem bus (page ADDR_PAGE), prescaler, one-shot/auto-reload, W1C expiry flag, level irq.
// Latency     : bus acknowledge and registered read data one cycle after select; writes land on that same acknowledge edge.
// Backpressure: none; every selected request is acked after one cycle, so back-to-back requests complete at most every 2 cycles.
//
// Ports:
//   clk, resetn        system clock, synchronous active-low reset
//   iomem_valid/ready  request valid / one-cycle acknowledge
//   iomem_wstrb        byte write strobes, 0 = read
//   iomem_addr/wdata   byte address / write data
//   iomem_rdata        registered read data, valid with iomem_ready
//   irq                level interrupt = STATUS.expired & CTRL.irq_en
//   pwm_out            registered (en && COUNT < DUTY) when IOMEM_TIMER_PWM_EN is defined, else 0
//
// Optional build macro: IOMEM_TIMER_PWM_EN adds the DUTY register and the PWM comparator.
// PRESCALE_W is expected in the range 1..31.

module iomem_timer #(
    parameter logic [7:0] ADDR_PAGE  = 8'h04,
    parameter int         PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq,
    output logic        pwm_out
);

    localparam logic [5:0] OFF_CTRL     = 6'h00;
    localparam logic [5:0] OFF_PRESCALE = 6'h01;
    localparam logic [5:0] OFF_COUNT    = 6'h02;
    localparam logic [5:0] OFF_RELOAD   = 6'h03;
    localparam logic [5:0] OFF_STATUS   = 6'h04;
`ifdef IOMEM_TIMER_PWM_EN
    localparam logic [5:0] OFF_DUTY     = 6'h05;
`endif

    // Register state
    logic                  ctrl_en;
    logic                  ctrl_auto;
    logic                  ctrl_irq_en;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] psc_cnt;
    logic [31:0]           count;
    logic [31:0]           reload;
    logic                  expired;
`ifdef IOMEM_TIMER_PWM_EN
    logic [31:0]           duty;
`endif

    // Byte-lane merge of write data into an existing 32-bit value
    function automatic logic [31:0] wmerge(input logic [31:0] old_val,
                                           input logic [31:0] wd,
                                           input logic [3:0]  ws);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (ws[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    // Bus decode
    logic [5:0]  off;
    logic        sel;
    logic        wr;
    logic        ctrl_wr;
    logic        prescale_wr;
    logic        count_wr;
    logic        reload_wr;
    logic        status_w1c;
    logic [31:0] pre_new;
    logic [31:0] rd_val;

    assign off         = iomem_addr[7:2];
    assign sel         = iomem_valid && !iomem_ready && (iomem_addr[31:24] == ADDR_PAGE);
    assign wr          = sel && (iomem_wstrb != 4'b0000);
    // All CTRL bits live in lane 0, so only a lane-0 write touches CTRL.
    assign ctrl_wr     = wr && (off == OFF_CTRL) && iomem_wstrb[0];
    assign prescale_wr = wr && (off == OFF_PRESCALE);
    assign count_wr    = wr && (off == OFF_COUNT);
    assign reload_wr   = wr && (off == OFF_RELOAD);
    assign status_w1c  = wr && (off == OFF_STATUS) && iomem_wstrb[0] && iomem_wdata[0];
    assign pre_new     = wmerge(32'(prescale), iomem_wdata, iomem_wstrb);

    // Address bits outside the page/offset fields and the prescale bits
    // above PRESCALE_W are intentionally ignored.
    logic unused_bits;
    assign unused_bits = &{1'b0, iomem_addr[23:8], iomem_addr[1:0], pre_new[31:PRESCALE_W]};

    // Tick and expiry
    logic tick;
    logic tick_eff;
    logic expire;

    assign tick     = ctrl_en && (psc_cnt == prescale);
    // A bus write to COUNT, or a CTRL write that clears en, overrides the
    // tick in the same cycle: no decrement, reload or expiry happens.
    assign tick_eff = tick && !count_wr && !(ctrl_wr && !iomem_wdata[0]);
    assign expire   = tick_eff && (count == 32'd0);

    // Read mux
    always_comb begin
        rd_val = 32'd0;
        case (off)
            OFF_CTRL:     rd_val = {29'd0, ctrl_irq_en, ctrl_auto, ctrl_en};
            OFF_PRESCALE: rd_val = 32'(prescale);
            OFF_COUNT:    rd_val = count;
            OFF_RELOAD:   rd_val = reload;
            OFF_STATUS:   rd_val = {31'd0, expired};
`ifdef IOMEM_TIMER_PWM_EN
            OFF_DUTY:     rd_val = duty;
`endif
            default:      rd_val = 32'd0;
        endcase
    end

    // Bus response
    always_ff @(posedge clk) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= 32'd0;
        end else begin
            iomem_ready <= sel;
            if (sel) iomem_rdata <= rd_val;
        end
    end

    // CTRL
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ctrl_en     <= 1'b0;
            ctrl_auto   <= 1'b0;
            ctrl_irq_en <= 1'b0;
        end else if (ctrl_wr) begin
            // A CTRL write in the expiry cycle keeps the written en.
            ctrl_en     <= iomem_wdata[0];
            ctrl_auto   <= iomem_wdata[1];
            ctrl_irq_en <= iomem_wdata[2];
        end else if (expire && !ctrl_auto) begin
            ctrl_en     <= 1'b0;
        end
    end

    // PRESCALE and prescaler counter
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prescale <= '0;
            psc_cnt  <= '0;
        end else begin
            if (prescale_wr) prescale <= pre_new[PRESCALE_W-1:0];
            if (!ctrl_en || prescale_wr || tick) psc_cnt <= '0;
            else                                 psc_cnt <= psc_cnt + PRESCALE_W'(1);
        end
    end

    // COUNT and RELOAD
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count  <= 32'd0;
            reload <= 32'd0;
        end else begin
            if (reload_wr) reload <= wmerge(reload, iomem_wdata, iomem_wstrb);
            if (count_wr) begin
                count <= wmerge(count, iomem_wdata, iomem_wstrb);
            end else if (tick_eff) begin
                if (count != 32'd0) count <= count - 32'd1;
                else if (ctrl_auto) count <= reload;
            end
        end
    end

    // STATUS: expiry set takes priority over W1C
    always_ff @(posedge clk) begin
        if (!resetn)         expired <= 1'b0;
        else if (expire)     expired <= 1'b1;
        else if (status_w1c) expired <= 1'b0;
    end

    assign irq = expired && ctrl_irq_en;

`ifdef IOMEM_TIMER_PWM_EN
    logic duty_wr;
    assign duty_wr = wr && (off == OFF_DUTY);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            duty    <= 32'd0;
            pwm_out <= 1'b0;
        end else begin
            if (duty_wr) duty <= wmerge(duty, iomem_wdata, iomem_wstrb);
            pwm_out <= ctrl_en && (count < duty);
        end
    end
`else
    assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_iomem_timer.sv
module tb_iomem_timer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'd0;
    logic [31:0] iomem_addr = 32'd0;
    logic [31:0] iomem_wdata = 32'd0;
    logic [31:0] iomem_rdata;
    logic        irq;
    logic        pwm_out;

    localparam logic [31:0] A_CTRL     = 32'h0400_0000;
    localparam logic [31:0] A_PRESCALE = 32'h0400_0004;
    localparam logic [31:0] A_COUNT    = 32'h0400_0008;
    localparam logic [31:0] A_RELOAD   = 32'h0400_000C;
    localparam logic [31:0] A_STATUS   = 32'h0400_0010;
    localparam logic [31:0] A_DUTY     = 32'h0400_0014;
    localparam logic [31:0] A_UNMAP    = 32'h0400_0040;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model of the plain storage registers
    logic [31:0] m_reload = 32'd0;

    iomem_timer dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .irq         (irq),
        .pwm_out     (pwm_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int w;
        w = 0;
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wdata = d;
        iomem_wstrb = s;
        do begin
            @(posedge clk);
            #1;
            w++;
        end while (iomem_ready !== 1'b1 && w < 8);
        n_checks++;
        if (iomem_ready !== 1'b1)
            $display("FAIL bus_write_ack addr=%h: ready=%b, required 1 within 8 cycles", a, iomem_ready);
        else
            n_pass++;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output int lat);
        int w;
        w = 0;
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wstrb = 4'd0;
        do begin
            @(posedge clk);
            #1;
            w++;
        end while (iomem_ready !== 1'b1 && w < 8);
        n_checks++;
        if (iomem_ready !== 1'b1)
            $display("FAIL bus_read_ack addr=%h: ready=%b, required 1 within 8 cycles", a, iomem_ready);
        else
            n_pass++;
        d   = iomem_rdata;
        lat = w;
        iomem_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        wait_cycles(3);
        resetn = 1'b1;
        wait_cycles(1);
        n_checks++;
        if ({iomem_ready, irq, pwm_out} !== 3'b000 || iomem_rdata !== 32'd0)
            $display("FAIL reset_outputs: ready=%b irq=%b pwm=%b rdata=%h, required all 0",
                     iomem_ready, irq, pwm_out, iomem_rdata);
        else n_pass++;
    endtask

    task automatic test_handshake();
        logic [31:0] d;
        int lat;
        bus_read(A_COUNT, d, lat);
        n_checks++;
        if (lat !== 1) $display("FAIL read_latency: got %0d cycles, required 1", lat);
        else n_pass++;
        n_checks++;
        if (d !== 32'd0) $display("FAIL count_after_reset: got %h, required 0", d);
        else n_pass++;
        wait_cycles(1);
        n_checks++;
        if (iomem_ready !== 1'b0) $display("FAIL ready_one_cycle: ready=%b one cycle after ack, required 0", iomem_ready);
        else n_pass++;
        // Only bits 2:0 of CTRL exist
        bus_write(A_CTRL, 32'hFFFF_FFF4, 4'hF);
        bus_read(A_CTRL, d, lat);
        n_checks++;
        if (d !== 32'h4) $display("FAIL ctrl_bits: got %h, required 00000004", d);
        else n_pass++;
        n_checks++;
        if (irq !== 1'b0) $display("FAIL irq_no_expiry: got %b, required 0", irq);
        else n_pass++;
        bus_write(A_UNMAP, 32'hFFFF_FFFF, 4'hF);
        bus_read(A_UNMAP, d, lat);
        n_checks++;
        if (d !== 32'd0) $display("FAIL unmapped_read: got %h, required 0", d);
        else n_pass++;
        bus_write(A_CTRL, 32'd0, 4'hF);
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d;
        logic [31:0] wd;
        logic [3:0]  ws;
        int lat;
        int seen;
        bus_write(A_RELOAD, 32'hAABB_CCDD, 4'b0101);
        m_reload = 32'h00BB_00DD;
        bus_read(A_RELOAD, d, lat);
        n_checks++;
        if (d !== 32'h00BB_00DD) $display("FAIL reload_lanes_0101: got %h, required 00BB00DD", d);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            wd = $urandom;
            ws = 4'($urandom_range(1, 15));
            bus_write(A_RELOAD, wd, ws);
            for (int b = 0; b < 4; b++)
                if (ws[b]) m_reload[8*b +: 8] = wd[8*b +: 8];
            bus_read(A_RELOAD, d, lat);
            n_checks++;
            if (d !== m_reload) $display("FAIL reload_lanes_rand wstrb=%b: got %h, required %h", ws, d, m_reload);
            else n_pass++;
        end
        // Request on another page must not be answered or take effect
        seen = 0;
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0300_000C;
        iomem_wdata = 32'h1234_5678;
        iomem_wstrb = 4'hF;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (iomem_ready === 1'b1) seen++;
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'd0;
        wait_cycles(1);
        n_checks++;
        if (seen !== 0) $display("FAIL other_page_ready: ready seen %0d times, required 0", seen);
        else n_pass++;
        bus_read(A_RELOAD, d, lat);
        n_checks++;
        if (d !== m_reload) $display("FAIL other_page_write: RELOAD got %h, required %h", d, m_reload);
        else n_pass++;
    endtask

    // Cycles from enabling ack edge to irq rise, bounded by budget
    task automatic run_oneshot(input int p, input int c, output int k);
        bus_write(A_STATUS, 32'd1, 4'h1);
        bus_write(A_PRESCALE, 32'(p), 4'hF);
        bus_write(A_COUNT, 32'(c), 4'hF);
        bus_write(A_CTRL, 32'h5, 4'hF);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (irq !== 1'b1 && k < 200);
    endtask

    task automatic test_one_shot();
        logic [31:0] d;
        int lat;
        int k;
        run_oneshot(0, 3, k);
        n_checks++;
        if (k !== 4) $display("FAIL oneshot_latency: irq after %0d cycles, required 4", k);
        else n_pass++;
        bus_read(A_COUNT, d, lat);
        n_checks++;
        if (d !== 32'd0) $display("FAIL oneshot_count: got %h, required 0", d);
        else n_pass++;
        bus_read(A_CTRL, d, lat);
        n_checks++;
        if (d !== 32'h4) $display("FAIL oneshot_en_cleared: CTRL got %h, required 00000004", d);
        else n_pass++;
        bus_write(A_STATUS, 32'd1, 4'h1);
        n_checks++;
        if (irq !== 1'b0) $display("FAIL w1c_irq: irq=%b after W1C, required 0", irq);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            int p;
            int c;
            p = $urandom_range(0, 3);
            c = (i == 0) ? 0 : $urandom_range(1, 9);
            run_oneshot(p, c, k);
            n_checks++;
            if (k !== (c + 1) * (p + 1))
                $display("FAIL oneshot_rand p=%0d c=%0d: irq after %0d cycles, required %0d", p, c, k, (c + 1) * (p + 1));
            else n_pass++;
        end
        bus_write(A_STATUS, 32'd1, 4'h1);
    endtask

    task automatic test_auto_reload();
        logic [31:0] d;
        int lat;
        int c0;
        int c1;
        int c2;
        int n_exp;
        bus_write(A_STATUS, 32'd1, 4'h1);
        bus_write(A_PRESCALE, 32'd2, 4'hF);
        bus_write(A_RELOAD, 32'd4, 4'hF);
        bus_write(A_COUNT, 32'd4, 4'hF);
        bus_write(A_CTRL, 32'h7, 4'hF);
        c0 = cyc;
        while (irq !== 1'b1 && cyc - c0 < 100) wait_cycles(1);
        c1 = cyc;
        n_checks++;
        if (c1 - c0 !== 15) $display("FAIL auto_first_expiry: %0d cycles, required 15", c1 - c0);
        else n_pass++;
        bus_write(A_STATUS, 32'd1, 4'h1);
        while (irq !== 1'b1 && cyc - c1 < 100) wait_cycles(1);
        c2 = cyc;
        n_checks++;
        if (c2 - c1 !== (4 + 1) * (2 + 1)) $display("FAIL auto_period: %0d cycles, required 15", c2 - c1);
        else n_pass++;
        // Fresh start with irq disabled, count expiries by polling
        bus_write(A_CTRL, 32'h0, 4'hF);
        bus_write(A_STATUS, 32'd1, 4'h1);
        bus_write(A_COUNT, 32'd4, 4'hF);
        bus_write(A_CTRL, 32'h3, 4'hF);
        c0 = cyc;
        n_exp = 0;
        while (cyc - c0 < 100) begin
            bus_read(A_STATUS, d, lat);
            if (d[0]) begin
                n_exp++;
                bus_write(A_STATUS, 32'd1, 4'h1);
            end
        end
        n_checks++;
        if (n_exp !== 100 / 15) $display("FAIL auto_expiry_count: got %0d, required %0d", n_exp, 100 / 15);
        else n_pass++;
        n_checks++;
        if (irq !== 1'b0) $display("FAIL irq_gated: irq=%b with irq_en=0, required 0", irq);
        else n_pass++;
        bus_write(A_CTRL, 32'h0, 4'hF);
        bus_write(A_STATUS, 32'd1, 4'h1);
    endtask

    task automatic test_collisions();
        logic [31:0] d;
        int lat;
        // W1C landing on the expiry edge
        bus_write(A_PRESCALE, 32'd0, 4'hF);
        bus_write(A_COUNT, 32'd3, 4'hF);
        bus_write(A_CTRL, 32'h5, 4'hF);
        wait_cycles(3);
        bus_write(A_STATUS, 32'd1, 4'h1);
        n_checks++;
        if (irq !== 1'b1) $display("FAIL w1c_vs_expiry: irq=%b, required 1", irq);
        else n_pass++;
        bus_write(A_STATUS, 32'd1, 4'h1);
        // CTRL write clearing en on the expiry edge
        bus_write(A_COUNT, 32'd2, 4'hF);
        bus_write(A_CTRL, 32'h5, 4'hF);
        wait_cycles(2);
        bus_write(A_CTRL, 32'h4, 4'hF);
        bus_read(A_STATUS, d, lat);
        n_checks++;
        if (d !== 32'd0) $display("FAIL ctrl_clear_vs_expiry: STATUS got %h, required 0", d);
        else n_pass++;
        // COUNT write on a tick edge (PRESCALE=7: first tick 8 cycles after enable)
        bus_write(A_PRESCALE, 32'd7, 4'hF);
        bus_write(A_COUNT, 32'd50, 4'hF);
        bus_write(A_CTRL, 32'h1, 4'hF);
        wait_cycles(7);
        bus_write(A_COUNT, 32'd10, 4'hF);
        bus_write(A_CTRL, 32'h0, 4'hF);
        bus_read(A_COUNT, d, lat);
        n_checks++;
        if (d !== 32'd10) $display("FAIL count_write_vs_tick: got %0d, required 10", d);
        else n_pass++;
    endtask

    task automatic test_reset_mid_count();
        logic [31:0] d;
        int lat;
        logic [31:0] regs [5];
        regs[0] = A_CTRL;
        regs[1] = A_PRESCALE;
        regs[2] = A_COUNT;
        regs[3] = A_RELOAD;
        regs[4] = A_STATUS;
        bus_write(A_PRESCALE, 32'd0, 4'hF);
        bus_write(A_RELOAD, 32'h1234, 4'hF);
        bus_write(A_COUNT, 32'd0, 4'hF);
        bus_write(A_CTRL, 32'h7, 4'hF);
        wait_cycles(3);
        n_checks++;
        if (irq !== 1'b1) $display("FAIL pre_reset_irq: irq=%b, required 1", irq);
        else n_pass++;
        resetn = 1'b0;
        wait_cycles(1);
        n_checks++;
        if ({irq, iomem_ready, pwm_out} !== 3'b000 || iomem_rdata !== 32'd0)
            $display("FAIL mid_reset_outputs: irq=%b ready=%b pwm=%b rdata=%h, required all 0",
                     irq, iomem_ready, pwm_out, iomem_rdata);
        else n_pass++;
        resetn = 1'b1;
        m_reload = 32'd0;
        wait_cycles(1);
        for (int i = 0; i < 5; i++) begin
            bus_read(regs[i], d, lat);
            n_checks++;
            if (d !== 32'd0) $display("FAIL reg_after_reset addr=%h: got %h, required 0", regs[i], d);
            else n_pass++;
        end
    endtask

    task automatic test_pwm();
        logic [31:0] d;
        int lat;
        int highs;
        logic [31:0] exp_duty;
        bus_write(A_PRESCALE, 32'd0, 4'hF);
        bus_write(A_RELOAD, 32'd9, 4'hF);
        bus_write(A_DUTY, 32'd3, 4'hF);
        bus_write(A_COUNT, 32'd9, 4'hF);
        bus_write(A_CTRL, 32'h3, 4'hF);
        bus_read(A_DUTY, d, lat);
`ifdef IOMEM_TIMER_PWM_EN
        exp_duty = 32'd3;
`else
        exp_duty = 32'd0;
`endif
        n_checks++;
        if (d !== exp_duty) $display("FAIL duty_read: got %h, required %h", d, exp_duty);
        else n_pass++;
        wait_cycles(20);
        highs = 0;
        for (int k = 0; k < 100; k++) begin
            if (pwm_out === 1'b1) highs++;
            wait_cycles(1);
        end
        n_checks++;
        // Steady state: high while COUNT < DUTY, period RELOAD+1 cycles
        if (highs !== 100 / (9 + 1) * int'(exp_duty))
            $display("FAIL pwm_high_cycles: got %0d of 100, required %0d", highs, 100 / (9 + 1) * int'(exp_duty));
        else n_pass++;
        bus_write(A_CTRL, 32'h0, 4'hF);
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_byte_lanes();
        test_one_shot();
        test_auto_reload();
        test_collisions();
        test_reset_mid_count();
        test_pwm();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/iomem_timer.md
Name: iomem_timer

Overview:
- Memory-mapped 32-bit down-counting timer on the PicoSoC iomem peripheral bus. It sits alongside the GPIO register block and decodes its own address page.
- Its level interrupt output drives the SoC irq_5 input, which is currently tied low.
- Provides a programmable prescaler, one-shot or auto-reload modes, and a write-1-to-clear expiry flag.

Parameters:
- ADDR_PAGE, 8'h04: value of iomem_addr[31:24] that selects this block.
- PRESCALE_W, 16: width of the prescaler register and prescaler counter.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous reset, active-low.
- iomem_valid  in  1  bus request valid.
- iomem_ready  out  1  one-cycle acknowledge.
- iomem_wstrb  in  4  byte write strobes; 0 means a read.
- iomem_addr  in  32  byte address.
- iomem_wdata  in  32  write data.
- iomem_rdata  out  32  registered read data, valid when iomem_ready is 1.
- irq  out  1  level interrupt; equals STATUS.expired AND CTRL.irq_en.
- pwm_out  out  1  PWM output (see Optional Feature).

Behaviour:
- Reset: resetn low at a clk edge clears everything to 0:
  - iomem_ready, iomem_rdata, irq, pwm_out.
  - CTRL, PRESCALE, COUNT, RELOAD, STATUS, DUTY, and the prescaler counter.
- Select condition: iomem_valid && !iomem_ready && iomem_addr[31:24]==ADDR_PAGE.
- Bus handshake:
  - When selected, iomem_ready=1 on the next cycle for exactly one cycle.
  - iomem_rdata is registered in that same edge, so read latency is 1 cycle.
  - Back-to-back requests therefore complete at most every 2 cycles.
  - When not selected, iomem_ready=0 and iomem_rdata holds its last value.
- Writes take effect at the acknowledge edge. Each byte lane is written only when its wstrb bit is set.
- Register map, decoded on iomem_addr[7:2]:
  - 0x00 CTRL: bit0 en, bit1 auto_reload, bit2 irq_en; other bits read 0.
  - 0x04 PRESCALE: [PRESCALE_W-1:0]; any write also clears the prescaler counter.
  - 0x08 COUNT: read returns the live count; write loads the count.
  - 0x0C RELOAD: 32-bit reload value.
  - 0x10 STATUS: bit0 expired; writing 1 to bit0 (lane 0) clears it, writing 0 has no effect.
  - 0x14 DUTY: 32-bit PWM threshold.
- Unmapped offsets: acknowledged normally, read 0, writes ignored.
- Prescaler:
  - While en=0, the prescaler counter is held at 0 and COUNT is frozen.
  - While en=1, the prescaler counter increments every cycle.
  - When the prescaler counter equals PRESCALE, a tick is generated and the counter wraps to 0.
  - PRESCALE=0 therefore gives a tick every cycle.
- On each tick:
  - If COUNT!=0, COUNT decrements by 1.
  - If COUNT==0, the timer expires:
    - expired is set to 1.
    - If auto_reload=1, COUNT is loaded with RELOAD.
    - If auto_reload=0, en is cleared and COUNT stays at 0.
- Period in auto-reload mode is (RELOAD+1)*(PRESCALE+1) cycles.
- Simultaneous events:
  - A bus write to COUNT and a tick in the same cycle: the write wins and the tick is discarded.
  - A bus write to CTRL clearing en and a tick in the same cycle: the write wins and no expiry occurs.
  - A STATUS W1C and an expiry in the same cycle: set wins, expired=1.
  - Expiry clears en only if the same cycle does not also carry a bus write to CTRL lane 0.
- irq is combinational from the registered flags; it has no extra latency beyond the flag edge.
- All arithmetic wraps modulo 2^32. COUNT never decrements below 0 because expiry is taken instead.

Optional Feature:
- Macro: IOMEM_TIMER_PWM_EN.
- Defined:
  - DUTY register is implemented.
  - pwm_out is registered, updated every cycle as (en && COUNT < DUTY).
  - pwm_out is 0 after reset.
- Undefined:
  - DUTY reads 0 and writes are ignored.
  - pwm_out is tied to 0.
  - No DUTY comparator is synthesized.
- The port list is identical in both builds.

Test Plan:
- Bus handshake: read 0x0400_0008 after reset -> iomem_ready high exactly 1 cycle, 1 cycle after valid; rdata=0. Read 0x0400_0040 -> ready, rdata=0.
- Byte lanes: write RELOAD=0xAABBCCDD with wstrb=4'b0101 -> read back 0x00BB00DD. Write with addr[31:24]=0x03 -> no ready from this block, RELOAD unchanged.
- One-shot: PRESCALE=0, COUNT=3, CTRL=0x5 ->
  - expired and irq rise 4 cycles after the enabling ack edge.
  - COUNT=0, CTRL.en reads 0.
  - Write STATUS=1 -> irq low the next cycle.
- Auto-reload with prescaler: PRESCALE=2, RELOAD=4, COUNT=4, CTRL=0x3 -> expired first sets at cycle 15, period 15 cycles. Free-running for 100 cycles -> 6 expiries counted via W1C polling.
- Collisions:
  - W1C of STATUS in the expiry cycle -> expired stays 1.
  - Write COUNT=10 in a tick cycle -> COUNT reads 10, not 9.
  - resetn asserted mid-count -> all registers 0, irq=0 the next cycle.
- With IOMEM_TIMER_PWM_EN: PRESCALE=0, RELOAD=9, DUTY=3, auto-reload -> pwm_out high 3 of every 10 cycles. Without the macro -> pwm_out=0 and DUTY reads 0.
